// File: rtl/decode_stage_sb.sv
// Vector processor decode stage: field split, control decode, RF read,
// per-register scoreboard, flush, HALT latch and ID/EX valid/ready register.
module decode_stage_sb #(
    parameter int REG_AW  = 4,
    parameter int SDATA_W = 8,
    parameter int VLANES  = 24,
    parameter int ELEM_W  = 8,
    parameter int IMM_W   = 8,
    parameter int CNT_W   = 16,
    localparam int VW      = VLANES * ELEM_W,
    localparam int INSTR_W = 8 + 3 * REG_AW + IMM_W,
    localparam int NREG    = 1 << REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  sra1,
    output logic [REG_AW-1:0]  sra2,
    output logic [REG_AW-1:0]  vra1,
    output logic [REG_AW-1:0]  vra2,
    input  logic [SDATA_W-1:0] srd1,
    input  logic [SDATA_W-1:0] srd2,
    input  logic [VW-1:0]      vrd1,
    input  logic [VW-1:0]      vrd2,
    input  logic               wb_valid,
    input  logic               wb_vec,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         ex_op,
    output logic               ex_use_imm,
    output logic [SDATA_W-1:0] ex_imm,
    output logic [SDATA_W-1:0] ex_s1,
    output logic [SDATA_W-1:0] ex_s2,
    output logic [VW-1:0]      ex_v1,
    output logic [VW-1:0]      ex_v2,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               ex_wb_en,
    output logic [REG_AW-1:0]  ex_dest,
    output logic               ex_dest_vec,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_LOAD  = 5'h10;
    localparam logic [4:0] OP_STORE = 5'h11;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    logic [4:0]        op;
    logic              vd, v1, v2;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]  imm;

    assign op  = instr[INSTR_W-1 -: 5];
    assign vd  = instr[INSTR_W-6];
    assign v1  = instr[INSTR_W-7];
    assign v2  = instr[INSTR_W-8];
    assign rd  = instr[IMM_W+3*REG_AW-1 -: REG_AW];
    assign rs1 = instr[IMM_W+2*REG_AW-1 -: REG_AW];
    assign rs2 = instr[IMM_W+REG_AW-1 -: REG_AW];
    assign imm = instr[IMM_W-1:0];

    assign sra1 = rs1;
    assign sra2 = rs2;
    assign vra1 = rs1;
    assign vra2 = rs2;

    logic is_nop, is_halt, is_store, use_imm;
    logic wb_en, use1, use2;
    logic busy1, busy2, busyd, hazard, accept;

    assign is_nop   = (op == OP_NOP);
    assign is_halt  = (op == OP_HALT);
    assign is_store = (op == OP_STORE);
    assign use_imm  = op[3];
    assign wb_en    = !(is_nop || is_store || is_halt);
    assign use1     = !(is_nop || is_halt);
    assign use2     = is_store || (use1 && !use_imm);

    logic [NREG-1:0] sb_s_q, sb_s_d, sb_v_q, sb_v_d;

    assign busy1  = v1 ? sb_v_q[rs1] : sb_s_q[rs1];
    assign busy2  = v2 ? sb_v_q[rs2] : sb_s_q[rs2];
    assign busyd  = vd ? sb_v_q[rd]  : sb_s_q[rd];
    assign hazard = (use1 && busy1) || (use2 && busy2) || (wb_en && busyd);

    logic out_valid_q, halted_q;
    logic [CNT_W-1:0] stall_q;

    assign in_ready = !halted_q && !flush && !hazard
                      && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Clear before set so a same-cycle retire/issue leaves the bit busy
    always_comb begin
        sb_s_d = sb_s_q;
        sb_v_d = sb_v_q;
        if (flush) begin
            sb_s_d = '0;
            sb_v_d = '0;
        end else begin
            if (wb_valid) begin
                if (wb_vec) sb_v_d[wb_addr] = 1'b0;
                else        sb_s_d[wb_addr] = 1'b0;
            end
            if (accept && wb_en) begin
                if (vd) sb_v_d[rd] = 1'b1;
                else    sb_s_d[rd] = 1'b1;
            end
        end
    end

    logic out_valid_d, halted_d;
    logic [CNT_W-1:0] stall_d;

    always_comb begin
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        stall_d     = stall_q;
        if (flush)                  out_valid_d = 1'b0;
        else if (accept)            out_valid_d = 1'b1;
        else if (out_ready)         out_valid_d = 1'b0;
        if (accept && is_halt)      halted_d    = 1'b1;
        if (in_valid && hazard && !halted_q && stall_q != '1)
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_s_q      <= '0;
            sb_v_q      <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            sb_s_q      <= sb_s_d;
            sb_v_q      <= sb_v_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            stall_q     <= stall_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op       <= '0;
            ex_imm      <= '0;
            ex_s1       <= '0;
            ex_s2       <= '0;
            ex_v1       <= '0;
            ex_v2       <= '0;
            ex_mem_rd   <= 1'b0;
            ex_mem_wr   <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_dest     <= '0;
            ex_dest_vec <= 1'b0;
        end else if (accept) begin
            ex_op       <= op;
            ex_imm      <= SDATA_W'(imm);
            ex_s1       <= srd1;
            ex_s2       <= srd2;
            ex_v1       <= vrd1;
            ex_v2       <= vrd2;
            ex_mem_rd   <= (op == OP_LOAD);
            ex_mem_wr   <= is_store;
            ex_wb_en    <= wb_en;
            ex_dest     <= rd;
            ex_dest_vec <= vd;
        end
    end

    assign ex_use_imm = ex_op[3];
    assign out_valid  = out_valid_q;
    assign halted     = halted_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Bench for decode_stage_sb: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the decode/scoreboard rules.
module tb_decode_stage_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 0, out_ready = 1, flush = 0;
    logic         wb_valid = 0, wb_vec = 0;
    logic [3:0]   wb_addr = 0;
    logic [4:0]   op = 0;
    logic         vd = 0, v1 = 0, v2 = 0;
    logic [3:0]   rd = 0, rs1 = 0, rs2 = 0;
    logic [7:0]   imm = 0;
    logic [27:0]  instr;
    logic [7:0]   srf [16];
    logic [191:0] vrf [16];
    logic [7:0]   srd1, srd2;
    logic [191:0] vrd1, vrd2;

    assign instr = {op, vd, v1, v2, rd, rs1, rs2, imm};
    assign srd1 = srf[rs1];
    assign srd2 = srf[rs2];
    assign vrd1 = vrf[rs1];
    assign vrd2 = vrf[rs2];

    logic         in_ready, out_valid, halted;
    logic [3:0]   sra1, sra2, vra1, vra2, ex_dest;
    logic [4:0]   ex_op;
    logic         ex_use_imm, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_dest_vec;
    logic [7:0]   ex_imm, ex_s1, ex_s2;
    logic [191:0] ex_v1, ex_v2;
    logic [15:0]  stall_cnt;

    decode_stage_sb dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .sra1(sra1), .sra2(sra2), .vra1(vra1), .vra2(vra2),
        .srd1(srd1), .srd2(srd2), .vrd1(vrd1), .vrd2(vrd2),
        .wb_valid(wb_valid), .wb_vec(wb_vec), .wb_addr(wb_addr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ex_op(ex_op), .ex_use_imm(ex_use_imm), .ex_imm(ex_imm),
        .ex_s1(ex_s1), .ex_s2(ex_s2), .ex_v1(ex_v1), .ex_v2(ex_v2),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_wb_en(ex_wb_en),
        .ex_dest(ex_dest), .ex_dest_vec(ex_dest_vec),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    int n_pass = 0, n_tot = 0;

    // model state: busy[type][reg], type 1 = vector
    bit           mb [2][16];
    bit           m_ov, m_halt;
    int           m_stall;
    logic [4:0]   e_op;
    logic [7:0]   e_imm, e_s1, e_s2;
    logic [191:0] e_v1, e_v2;
    logic         e_mrd, e_mwr, e_wbe, e_dvec;
    logic [3:0]   e_dest;
    bit           last_acc;

    task automatic chk(string tag, logic [191:0] o, logic [191:0] e);
        n_tot++;
        assert (o === e) n_pass++;
        else $error("FAIL %s got %h exp %h", tag, o, e);
    endtask

    task automatic model_reset();
        foreach (mb[t, r]) mb[t][r] = 0;
        m_ov = 0; m_halt = 0; m_stall = 0;
        e_op = 0; e_imm = 0; e_s1 = 0; e_s2 = 0; e_v1 = 0; e_v2 = 0;
        e_mrd = 0; e_mwr = 0; e_wbe = 0; e_dvec = 0; e_dest = 0;
    endtask

    task automatic chk_outs();
        chk("out_valid", out_valid, m_ov);
        chk("halted", halted, m_halt);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("ex_op", ex_op, e_op);
        chk("ex_use_imm", ex_use_imm, e_op[3]);
        chk("ex_imm", ex_imm, e_imm);
        chk("ex_s1", ex_s1, e_s1);
        chk("ex_s2", ex_s2, e_s2);
        chk("ex_v1", ex_v1, e_v1);
        chk("ex_v2", ex_v2, e_v2);
        chk("ex_mem_rd", ex_mem_rd, e_mrd);
        chk("ex_mem_wr", ex_mem_wr, e_mwr);
        chk("ex_wb_en", ex_wb_en, e_wbe);
        chk("ex_dest", ex_dest, e_dest);
        chk("ex_dest_vec", ex_dest_vec, e_dvec);
    endtask

    task automatic set_ins(logic [4:0] o, logic d, logic a, logic b,
                           logic [3:0] r, logic [3:0] s1, logic [3:0] s2,
                           logic [7:0] im);
        op = o; vd = d; v1 = a; v2 = b; rd = r; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1;
    endtask

    // one cycle: called just after a falling edge with inputs applied
    task automatic step();
        bit wbe, u1, u2, hz, rdy, acc;
        #1;
        wbe = !(op inside {5'h00, 5'h11, 5'h1F});
        u1  = !(op inside {5'h00, 5'h1F});
        u2  = (op == 5'h11) || (u1 && !op[3]);
        hz  = (u1 && mb[v1][rs1]) || (u2 && mb[v2][rs2])
              || (wbe && mb[vd][rd]);
        rdy = !m_halt && !flush && !hz && (!m_ov || out_ready);
        acc = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        chk("sra1", sra1, rs1);
        chk("vra2", vra2, rs2);
        if (in_valid && hz && !m_halt && m_stall < 65535) m_stall++;
        if (acc) begin
            e_op = op; e_imm = imm; e_s1 = srf[rs1]; e_s2 = srf[rs2];
            e_v1 = vrf[rs1]; e_v2 = vrf[rs2];
            e_mrd = (op == 5'h10); e_mwr = (op == 5'h11); e_wbe = wbe;
            e_dest = rd; e_dvec = vd;
            if (op == 5'h1F) m_halt = 1;
        end
        if (flush) begin
            foreach (mb[t, r]) mb[t][r] = 0;
            m_ov = 0;
        end else begin
            if (wb_valid) mb[wb_vec][wb_addr] = 0;
            if (acc && wbe) mb[vd][rd] = 1;
            if (acc) m_ov = 1;
            else if (out_ready) m_ov = 0;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk_outs();
        @(negedge clk);
        wb_valid = 0;
        flush = 0;
    endtask

    logic [4:0] oplist [8];

    initial begin
        oplist = '{5'h00, 5'h01, 5'h02, 5'h09, 5'h0A, 5'h10, 5'h11, 5'h05};
        for (int i = 0; i < 16; i++) begin
            srf[i] = 8'($urandom);
            vrf[i] = {$urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom};
        end
        srf[1] = 8'h05;
        srf[2] = 8'h07;
        vrf[4] = 192'h01;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_outs();
        rst_n = 1;
        @(negedge clk);

        // scalar ADD, then dependent op stalls until rd=3 retires
        set_ins(5'h01, 0, 0, 0, 4'd3, 4'd1, 4'd2, 8'h00);
        step();
        chk("add_s1", ex_s1, 8'h05);
        chk("add_s2", ex_s2, 8'h07);
        set_ins(5'h02, 0, 0, 0, 4'd6, 4'd3, 4'd2, 8'h00);
        step();
        step();
        wb_valid = 1; wb_vec = 0; wb_addr = 4'd3;
        step();
        step();
        chk("stall_total", stall_cnt, 16'd3);
        chk("dep_accepted", last_acc, 1'b1);

        // vector immediate op, then back-pressure for 3 cycles
        set_ins(5'h09, 1, 1, 0, 4'd2, 4'd4, 4'd0, 8'hA5);
        step();
        chk("vimm_imm", ex_imm, 8'hA5);
        out_ready = 0;
        set_ins(5'h01, 0, 0, 0, 4'd2, 4'd1, 4'd1, 8'h00);
        repeat (3) step();
        out_ready = 1;
        step();
        chk("scalar2_free", last_acc, 1'b1);

        // set scalar 3 and 5 busy, flush releases a stalled dependent
        set_ins(5'h01, 0, 0, 0, 4'd5, 4'd1, 4'd1, 8'h00);
        step();
        set_ins(5'h01, 0, 0, 0, 4'd3, 4'd1, 4'd1, 8'h00);
        step();
        set_ins(5'h01, 0, 0, 0, 4'd7, 4'd5, 4'd3, 8'h00);
        flush = 1;
        step();
        step();
        chk("after_flush", last_acc, 1'b1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            set_ins(oplist[$urandom_range(0, 7)], 1'($urandom),
                    1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
                    4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                    8'($urandom));
            in_valid = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_vec = 1'($urandom);
            wb_addr = 4'($urandom_range(0, 7));
            step();
        end

        // async reset in the middle of a stall
        out_ready = 1;
        set_ins(5'h01, 1, 0, 0, 4'd9, 4'd1, 4'd1, 8'h00);
        step();
        set_ins(5'h01, 0, 1, 0, 4'd8, 4'd9, 4'd1, 8'h00);
        step();
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        chk_outs();
        chk("rst_stall", stall_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1;
        step();

        // HALT is sticky and blocks further input
        set_ins(5'h1F, 0, 0, 0, 4'd1, 4'd0, 4'd0, 8'h00);
        step();
        chk("halt_wb_en", ex_wb_en, 1'b0);
        set_ins(5'h01, 0, 0, 0, 4'd4, 4'd1, 4'd1, 8'h00);
        repeat (4) step();
        chk("halt_sticky", halted, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
- Parametrised successor of the vector processor decode stage.
- Splits the instruction into fields and decodes control (exec/mem/wb).
- Drives read addresses to external scalar and vector register files.
- Registers operands and control into a valid/ready ID/EX pipeline register.
- Adds a per-register scoreboard for RAW/WAW stalls, a flush, a HALT latch and a saturating stall counter.

Parameters:
- REG_AW, 4, register address width; 2^REG_AW scalar and 2^REG_AW vector registers.
- SDATA_W, 8, scalar register width.
- VLANES, 24, vector lanes.
- ELEM_W, 8, lane width; vector width VW = VLANES*ELEM_W (192 default).
- IMM_W, 8, immediate field width, zero-extended to SDATA_W (IMM_W <= SDATA_W).
- CNT_W, 16, stall counter width.
- Localparam INSTR_W = 8 + 3*REG_AW + IMM_W (28 default).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  decode accepts this cycle.
- instr  in  INSTR_W  fields MSB→LSB: opcode[4:0], vd, v1, v2, rd, rs1, rs2, imm.
- sra1, sra2  out  REG_AW  scalar RF read addresses; combinational = rs1, rs2.
- vra1, vra2  out  REG_AW  vector RF read addresses; combinational = rs1, rs2.
- srd1, srd2  in  SDATA_W  scalar RF read data; combinational, same cycle.
- vrd1, vrd2  in  VW  vector RF read data; combinational, same cycle.
- wb_valid  in  1  writeback retiring a register.
- wb_vec  in  1  retiring register is vector (1) or scalar (0).
- wb_addr  in  REG_AW  retiring register index.
- flush  in  1  synchronous pipeline kill.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  execute accepts.
- ex_op  out  5  opcode.
- ex_use_imm  out  1  opcode[3].
- ex_imm  out  SDATA_W  zero-extended imm.
- ex_s1, ex_s2  out  SDATA_W  scalar operands.
- ex_v1, ex_v2  out  VW  vector operands.
- ex_mem_rd, ex_mem_wr, ex_wb_en  out  1  control.
- ex_dest  out  REG_AW  destination index.
- ex_dest_vec  out  1  destination type.
- halted  out  1  HALT accepted.
- stall_cnt  out  CNT_W  hazard-stall cycles, saturating.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, all ex_* = 0, scoreboard all clear, halted=0, stall_cnt=0.
- Decode:
  - NOP = 0x00.
  - mem_rd = (op==0x10); mem_wr = (op==0x11); HALT = 0x1F.
  - wb_en = 1 except NOP, STORE, HALT.
- Source usage:
  - rs1 is read for every op except NOP and HALT.
  - rs2 is read only when use_imm=0, op not in {NOP, HALT}, or op==STORE (store data).
  - vX selects vector vs scalar scoreboard for each source; vd selects it for the destination.
- Hazard (combinational, from the registered scoreboard only; no same-cycle bypass from wb_valid):
  - Any used source busy → stall.
  - Destination busy while wb_en=1 → stall (WAW).
- Handshake:
  - in_ready = !halted && !flush && !hazard && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - On accept, next cycle: out_valid=1 and all ex_* loaded (operands from srd/vrd); latency 1 cycle.
  - If out_valid && out_ready && !accept → out_valid=0.
  - If out_valid && !out_ready → ex_* held stable.
- Scoreboard (2×2^REG_AW bits):
  - Set bit (vd, rd) on accept with wb_en.
  - Clear bit (wb_vec, wb_addr) on wb_valid.
  - Set and clear of the same bit in the same cycle → set wins.
- Flush (priority over everything except reset):
  - Next cycle: out_valid=0, scoreboard fully cleared, no accept that cycle.
  - halted unaffected.
- HALT:
  - On accept, halted=1 (sticky until reset).
  - HALT itself passes to the output with wb_en=0.
- stall_cnt increments each cycle in_valid && hazard && !halted; saturates at all-ones.

Test Plan:
- Accept scalar ADD op=0x01, rd=3, rs1=1, rs2=2 with srd1=0x05, srd2=0x07, out_ready=1 → next cycle out_valid=1, ex_s1=0x05, ex_s2=0x07, ex_wb_en=1, ex_dest=3; scalar scoreboard bit 3 set.
- Issue rd=3 then immediately rs1=3 → in_ready=0 and stall_cnt increments each cycle; wb_valid (scalar, 3) → in_ready=1 the cycle after, dependent op accepted, stall_cnt=number of stall cycles.
- Vector op=0x09 (imm) vd=1, v1=1, rd=2, rs1=4, imm=0xA5, vrd1=192'h…01 → ex_v1=vrd1, ex_use_imm=1, ex_imm=0x00A5 (zero-extended); vector bit 2 set, scalar bit 2 clear.
- out_ready=0 for 3 cycles after issue → ex_* unchanged, in_ready=0; out_ready=1 → drains, next instruction accepted same cycle.
- Scoreboard bits 3 and 5 set, flush=1 for 1 cycle → out_valid=0, scoreboard clear; prior dependent stalled op accepted next cycle.
- HALT accepted → halted=1, in_ready=0 forever; assert rst_n=0 mid-stall → all outputs 0 immediately (async), stall_cnt=0.
